mem_stream_ctrl: RTL and testbench

- Stream-to-memory controller placed directly upstream and downstream of the team's simple dual-port `memory` block (synchronous write port, read port with fixed read latency).
- Accepts a valid/ready input stream and writes it into the memory ring. Issues reads in FIFO order and captures the returned data into a small flop-based output buffer.
- Presents the output as a valid/ready stream, so the memory behaves as a flow-controlled FIFO.

---
 rtl/mem_stream_ctrl.sv | 87 ++++++++
 tb/tb_mem_stream_ctrl.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_ctrl.sv
// mem_stream_ctrl: valid/ready wrapper that turns a simple dual-port memory into a flow-controlled FIFO
module mem_stream_ctrl #(
  parameter int DATA_WIDTH = 4,
  parameter int MEM_DEPTH  = 3,
  parameter int RD_LATENCY = 1,
  parameter int ADDR_WIDTH = $clog2(MEM_DEPTH),
  parameter int OBUF_DEPTH = RD_LATENCY + 1,
  parameter int LVL_WIDTH  = $clog2(MEM_DEPTH + OBUF_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [LVL_WIDTH-1:0]  level
);
  localparam int CW  = $clog2(MEM_DEPTH + 1);
  localparam int KW  = $clog2(2 * OBUF_DEPTH + 2);
  localparam int OW  = $clog2(OBUF_DEPTH);
  localparam int OCW = $clog2(OBUF_DEPTH + 1);
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0]         mem_count;
  logic [RD_LATENCY-1:0] vld_sr;
  logic [RD_LATENCY:0]   vld_nxt;
  logic [KW-1:0]         inflight;
  logic [DATA_WIDTH-1:0] obuf [OBUF_DEPTH];
  logic [OW-1:0]         head, tail;
  logic [OCW-1:0]        obuf_count;
  logic                  in_fire, pop, push;
  assign in_ready    = reset && (mem_count < CW'(MEM_DEPTH));
  assign in_fire     = in_valid && in_ready;
  assign mem_wr_en   = in_fire;
  assign mem_wr_addr = wr_ptr;
  assign mem_wr_data = reset ? in_data : '0;
  assign out_valid   = obuf_count != '0;
  assign out_data    = obuf[head];
  assign pop         = out_valid && out_ready;
  assign push        = vld_sr[RD_LATENCY-1];
  // credit: words already in flight plus buffered words must leave room for this read
  assign mem_rd_en   = reset && (mem_count != '0) &&
                       (inflight + KW'(obuf_count) < KW'(OBUF_DEPTH) + KW'(pop));
  assign mem_rd_addr = rd_ptr;
  assign vld_nxt     = {vld_sr, mem_rd_en};
  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + KW'(vld_sr[i]);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_count <= '0;
      vld_sr    <= '0;
      level     <= '0;
    end else begin
      if (in_fire) wr_ptr <= (wr_ptr == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : wr_ptr + ADDR_WIDTH'(1);
      if (mem_rd_en) rd_ptr <= (rd_ptr == ADDR_WIDTH'(MEM_DEPTH - 1)) ? '0 : rd_ptr + ADDR_WIDTH'(1);
      mem_count <= mem_count + CW'(in_fire) - CW'(mem_rd_en);
      vld_sr    <= vld_nxt[RD_LATENCY-1:0];
      level     <= level + LVL_WIDTH'(in_fire) - LVL_WIDTH'(pop);
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head       <= '0;
      tail       <= '0;
      obuf_count <= '0;
      for (int i = 0; i < OBUF_DEPTH; i++) obuf[i] <= '0;
    end else begin
      if (push) begin
        obuf[tail] <= mem_rd_data;
        tail       <= (tail == OW'(OBUF_DEPTH - 1)) ? '0 : tail + OW'(1);
      end
      if (pop) head <= (head == OW'(OBUF_DEPTH - 1)) ? '0 : head + OW'(1);
      obuf_count <= obuf_count + OCW'(push) - OCW'(pop);
    end
  end
endmodule

// File: tb/tb_mem_stream_ctrl.sv
// tb_mem_stream_ctrl: randomized self-checking bench with a behavioural memory and a queue reference model
module tb_mem_stream_ctrl;
  localparam int DW = 4;
  localparam int MD = 3;
  localparam int RL = 1;
  localparam int AW = $clog2(MD);
  localparam int LW = $clog2(MD + RL + 2);
  logic          clk = 0, reset = 0, in_valid = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, mem_wr_en, mem_rd_en;
  logic [DW-1:0] out_data, mem_wr_data, mem_rd_data;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [LW-1:0] level;
  logic [DW-1:0] mem [MD];
  logic [DW-1:0] rd_pipe [RL];
  logic [DW-1:0] q [$];
  int tests = 0, fails = 0;

  mem_stream_ctrl dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data), .level(level)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wr_en && mem_wr_addr < AW'(MD)) mem[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en && mem_rd_addr < AW'(MD)) rd_pipe[0] <= mem[mem_rd_addr];
    for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rd_data = rd_pipe[RL-1];

  task automatic test_reset();
    reset = 0; in_valid = 1; in_data = 4'hA; out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL reset_in_ready got=%0b exp=0", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      tests++; if (mem_wr_en !== 1'b0 || mem_rd_en !== 1'b0) begin fails++; $display("FAIL reset_mem_en got=%0b%0b exp=00", mem_wr_en, mem_rd_en); end
      tests++; if (level !== '0) begin fails++; $display("FAIL reset_level got=%0d exp=0", level); end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 0; reset = 1;
    @(negedge clk);
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL release_in_ready got=%0b exp=1", in_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_fill();
    logic [DW-1:0] words [5] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd3};
    logic [AW-1:0] waddr [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    logic [AW-1:0] raddr [$];
    out_ready = 0;
    for (int c = 0; c < 9; c++) begin
      in_valid = 1; in_data = c < 5 ? words[c] : 4'hF;
      @(negedge clk);
      if (c < 5) begin
        tests++; if (!(in_ready && mem_wr_en) || mem_wr_addr !== waddr[c] || mem_wr_data !== words[c]) begin
          fails++; $display("FAIL fill_write%0d got en=%0b addr=%0d data=%0d exp en=1 addr=%0d data=%0d", c, mem_wr_en, mem_wr_addr, mem_wr_data, waddr[c], words[c]);
        end
        q.push_back(words[c]);
      end else begin
        tests++; if (in_ready !== 1'b0 || mem_wr_en !== 1'b0) begin fails++; $display("FAIL fill_full%0d in_ready=%0b wr_en=%0b exp 0", c, in_ready, mem_wr_en); end
        tests++; if (level !== LW'(5)) begin fails++; $display("FAIL fill_level got=%0d exp=5", level); end
      end
      if (mem_rd_en) raddr.push_back(mem_rd_addr);
      @(posedge clk); #1;
    end
    in_valid = 0;
    tests++; if (raddr.size() != 2 || raddr[0] !== 2'd0 || raddr[1] !== 2'd1) begin
      fails++; $display("FAIL fill_rd_addrs got count=%0d exp reads at 0,1 only", raddr.size());
    end
  endtask

  task automatic test_drain();
    out_ready = 1; in_valid = 0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      if (c < 5) begin
        tests++; if (out_valid !== 1'b1 || q.size() == 0 || out_data !== q[0]) begin
          fails++; $display("FAIL drain%0d got valid=%0b data=%0d exp data=%0d", c, out_valid, out_data, q.size() ? q[0] : 4'h0);
        end
        if (q.size()) void'(q.pop_front());
      end else begin
        tests++; if (out_valid !== 1'b0 || level !== '0) begin fails++; $display("FAIL drain_empty valid=%0b level=%0d exp 0/0", out_valid, level); end
      end
      @(posedge clk); #1;
    end
    out_ready = 0;
  endtask

  task automatic test_latency();
    out_ready = 1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c == 0); in_data = 4'd5;
      @(negedge clk);
      tests++; if (out_valid !== (c == 3)) begin fails++; $display("FAIL latency_c%0d out_valid=%0b exp=%0b", c, out_valid, c == 3); end
      if (c == 3) begin tests++; if (out_data !== 4'd5) begin fails++; $display("FAIL latency_data got=%0d exp=5", out_data); end end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 0;
  endtask

  // mode 0: continuous stream, mode 1: out_ready toggles 1010, mode 2: random valid/ready/data
  task automatic test_flow(input int mode, input int n);
    int sent = 0, got = 0, cyc = 0, first = -1, last = -1;
    logic [DW-1:0] cur = mode == 2 ? DW'($urandom) : '0;
    while ((sent < n || q.size() != 0) && cyc < 600) begin
      in_valid  = (sent < n) && (mode < 2 || $urandom_range(0, 3) != 0);
      in_data   = cur;
      out_ready = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : ($urandom_range(0, 2) != 0);
      @(negedge clk);
      tests++; if (level !== LW'(q.size()) || level > LW'(5)) begin fails++; $display("FAIL flow%0d_level c=%0d got=%0d exp=%0d", mode, cyc, level, q.size()); end
      if (mode == 0 && sent < n) begin tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL flow0_in_ready c=%0d got=0 exp=1", cyc); end end
      if (mem_wr_en && mem_wr_addr >= AW'(MD) || mem_rd_en && mem_rd_addr >= AW'(MD)) begin
        tests++; fails++; $display("FAIL flow%0d_addr_range wr=%0d rd=%0d exp <%0d", mode, mem_wr_addr, mem_rd_addr, MD);
      end
      if (out_valid && out_ready) begin
        tests++; if (q.size() == 0 || out_data !== q[0]) begin fails++; $display("FAIL flow%0d_data c=%0d got=%0d exp=%0d", mode, cyc, out_data, q.size() ? q[0] : 4'h0); end
        if (q.size()) void'(q.pop_front());
        got++; if (first < 0) first = cyc; last = cyc;
      end
      if (in_valid && in_ready) begin
        q.push_back(in_data); sent++;
        cur = mode == 2 ? DW'($urandom) : DW'(sent);
      end
      @(posedge clk); #1; cyc++;
    end
    in_valid = 0; out_ready = 0;
    tests++; if (got != n) begin fails++; $display("FAIL flow%0d_count got=%0d exp=%0d", mode, got, n); end
    if (mode == 0) begin tests++; if (last - first != n - 1) begin fails++; $display("FAIL flow0_rate span=%0d exp=%0d", last - first, n - 1); end end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] words [3] = '{4'd9, 4'd10, 4'd11};
    out_ready = 0;
    for (int c = 0; c < 3; c++) begin
      in_valid = 1; in_data = words[c];
      @(negedge clk); @(posedge clk); #1;
    end
    in_valid = 0;
    @(negedge clk);
    tests++; if (level !== LW'(3)) begin fails++; $display("FAIL mid_pre_level got=%0d exp=3", level); end
    reset = 0; q.delete();
    #1;
    tests++; if (level !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_reset level=%0d valid=%0b exp 0/0", level, out_valid); end
    @(posedge clk); #1; reset = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      tests++; if (level !== '0 || out_valid !== 1'b0) begin fails++; $display("FAIL mid_stale%0d level=%0d valid=%0b exp 0/0", c, level, out_valid); end
      @(posedge clk); #1;
    end
    out_ready = 1;
    for (int c = 0; c < 6; c++) begin
      in_valid = (c == 0); in_data = 4'd7;
      @(negedge clk);
      if (out_valid) begin
        tests++; if (c != 3 || out_data !== 4'd7) begin fails++; $display("FAIL mid_first_word c=%0d got=%0d exp=7 at c=3", c, out_data); end
      end else if (c == 3) begin
        tests++; fails++; $display("FAIL mid_first_word c=3 got no word exp=7");
      end
      @(posedge clk); #1;
    end
    in_valid = 0; out_ready = 0;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_latency();
    test_flow(0, 16);
    test_flow(1, 16);
    test_flow(2, 120);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
